addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
Two-requester round-robin arbiter sharing a single N-bit adder/subtractor between pipeline clients (e.g. ALU and branch-target path). Each requester uses a valid/ready request channel. The block registers one result per cycle onto a shared result channel tagged with the requester ID, with backpressure. Sits between the requesting pipeline stages and the one shared adder/subtractor instance.

Parameters:
N, 32, operand/result width in bits

Ports:
i_CLK  input  1  clock, all state updates on rising edge
i_RSTn  input  1  synchronous active-low reset
i_REQ0_VALID  input  1  requester 0 has an operation pending
o_REQ0_READY  output  1  requester 0 operation accepted this cycle (when VALID=1)
i_REQ0_A  input  N  requester 0 operand A
i_REQ0_B  input  N  requester 0 operand B
i_REQ0_SUB  input  1  requester 0 op: 0=A+B, 1=A-B
i_REQ1_VALID  input  1  requester 1 has an operation pending
o_REQ1_READY  output  1  requester 1 operation accepted this cycle
i_REQ1_A  input  N  requester 1 operand A
i_REQ1_B  input  N  requester 1 operand B
i_REQ1_SUB  input  1  requester 1 op: 0=add, 1=subtract
o_RES_VALID  output  1  result register holds an unconsumed result
i_RES_READY  input  1  consumer takes the result this cycle
o_RES_ID  output  1  requester ID owning the current result
o_RES_S  output  N  registered sum/difference (mod 2^N)
o_RES_OVFL  output  1  registered overflow flag from the shared unit

Behaviour:
- Clock/reset: one clock, i_CLK; reset i_RSTn is synchronous, active-low.
- Reset (i_RSTn=0 at an edge): o_RES_VALID=0, o_RES_ID=0, o_RES_S=0, o_RES_OVFL=0, last-grant pointer=1. While i_RSTn=0, both READY outputs are forced 0.
- Slot free: slot_free = !o_RES_VALID | i_RES_READY. Draining and accepting in the same cycle is allowed, giving a throughput of 1 op/cycle.
- Arbitration (combinational, only when slot_free=1):
  - If exactly one VALID is high, grant that requester.
  - If both are high, grant the requester != last-grant pointer.
  - Neither: no grant. Slot not free: no grant and both READY=0.
- READY: o_REQk_READY=1 only for the granted k. At most one READY is high per cycle. READY never depends on that requester's own operands.
- Shared unit: operands and SUB of the granted requester are muxed into the one adder/subtractor instance. Subtract is A + (~B + 1) mod 2^N. With no grant, the mux selects requester 0; the output is don't-care.
- Accept (VALID&READY at edge):
  - Next cycle o_RES_VALID=1 with o_RES_S, o_RES_OVFL and o_RES_ID=k.
  - Latency is exactly 1 cycle.
  - Last-grant pointer <= k.
- Hold: while o_RES_VALID=1 and i_RES_READY=0, o_RES_S/OVFL/ID hold stable and no new request is granted.
- Drain, no accept: o_RES_VALID<=0. Data registers keep their last values.
- Pointer: updates only on an accept, not on idle cycles. A lone requester may be granted back-to-back indefinitely.
- Requester rule: a requester holds VALID and its operands stable until READY. The block does not latch requests before grant.
- Reset mid-operation: a pending result is discarded and the pointer returns to 1, so requester 0 wins the next tie.
- Fairness: with both VALID continuously asserted and the consumer always ready, grants alternate 0,1,0,1 starting with 0 after reset.

Decomposition:
- Shared constants in a common package/include: REQ_ID_0=1'b0, REQ_ID_1=1'b1, OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: the existing Add_Sub adder/subtractor, instantiated once with N passed through. SUB drives its nAdd_Sub input.
- Arbiter logic, operand mux and the result register live in addsub_arbiter itself; no further sub-modules.

Test Plan:
- Reset: hold i_RSTn=0 for 2 cycles with both VALID=1 -> READYs=0, o_RES_VALID=0, o_RES_S=0; after release, first tie grants requester 0.
- Single op: req0 A=5, B=3, SUB=1, consumer ready -> READY0=1 in the same cycle; next cycle o_RES_VALID=1, ID=0, S=2. Then req1 A=0xFFFFFFFF, B=1, SUB=0 -> S=0, ID=1.
- Round-robin: both VALID held for 4 accepts, consumer ready -> IDs 0,1,0,1 on consecutive cycles, one result per cycle.
- Backpressure: result pending, i_RES_READY=0 for 3 cycles with both VALID -> READYs=0; o_RES_S/ID stable. Raising RES_READY -> same-cycle grant, and the new result appears the next cycle.
- Subtract wrap: A=0, B=1, SUB=1 -> S=0xFFFFFFFF; OVFL equals the shared unit's flag for those operands.
- Mid-op reset: assert i_RSTn=0 while o_RES_VALID=1 and RES_READY=0 -> o_RES_VALID=0 next edge; after release with both VALID, requester 0 is granted.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - shared constants for the add/sub arbiter
package addsub_arbiter_pkg;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;

endpackage

// File: rtl/addsub_arbiter_add_sub.sv
// rtl/addsub_arbiter_add_sub.sv - N-bit adder/subtractor with signed overflow flag
module Add_Sub #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         nAdd_Sub,
  output logic [N-1:0] S,
  output logic         OVFL
);

  logic [N-1:0] b_eff;

  // Subtract as A + ~B + 1; the carry-in rides on nAdd_Sub.
  assign b_eff = nAdd_Sub ? ~B : B;
  assign S     = A + b_eff + {{(N-1){1'b0}}, nAdd_Sub};
  assign OVFL  = (A[N-1] == b_eff[N-1]) && (S[N-1] != A[N-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin arbiter over one shared adder/subtractor
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_CLK,
  input  logic         i_RSTn,
  input  logic         i_REQ0_VALID,
  output logic         o_REQ0_READY,
  input  logic [N-1:0] i_REQ0_A,
  input  logic [N-1:0] i_REQ0_B,
  input  logic         i_REQ0_SUB,
  input  logic         i_REQ1_VALID,
  output logic         o_REQ1_READY,
  input  logic [N-1:0] i_REQ1_A,
  input  logic [N-1:0] i_REQ1_B,
  input  logic         i_REQ1_SUB,
  output logic         o_RES_VALID,
  input  logic         i_RES_READY,
  output logic         o_RES_ID,
  output logic [N-1:0] o_RES_S,
  output logic         o_RES_OVFL
);

  logic         res_valid_q, res_valid_d;
  logic         res_id_q, res_id_d;
  logic [N-1:0] res_s_q, res_s_d;
  logic         res_ovfl_q, res_ovfl_d;
  logic         last_q, last_d;

  logic         slot_free;
  logic         gnt0, gnt1, accept, sel;
  logic [N-1:0] mux_a, mux_b;
  logic         mux_sub;
  logic [N-1:0] unit_s;
  logic         unit_ovfl;

  assign slot_free = !res_valid_q || i_RES_READY;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_RSTn && slot_free) begin
      if (i_REQ0_VALID && i_REQ1_VALID) begin
        gnt0 = (last_q == REQ_ID_1);
        gnt1 = (last_q == REQ_ID_0);
      end else begin
        gnt0 = i_REQ0_VALID;
        gnt1 = i_REQ1_VALID;
      end
    end
  end

  assign accept       = gnt0 || gnt1;
  assign sel          = gnt1 ? REQ_ID_1 : REQ_ID_0;
  assign o_REQ0_READY = gnt0;
  assign o_REQ1_READY = gnt1;

  assign mux_a   = sel ? i_REQ1_A   : i_REQ0_A;
  assign mux_b   = sel ? i_REQ1_B   : i_REQ0_B;
  assign mux_sub = sel ? i_REQ1_SUB : i_REQ0_SUB;

  Add_Sub #(.N(N)) u_add_sub (
    .A        (mux_a),
    .B        (mux_b),
    .nAdd_Sub (mux_sub),
    .S        (unit_s),
    .OVFL     (unit_ovfl)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_s_d     = res_s_q;
    res_ovfl_d  = res_ovfl_q;
    last_d      = last_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_id_d    = sel;
      res_s_d     = unit_s;
      res_ovfl_d  = unit_ovfl;
      last_d      = sel;
    end else if (i_RES_READY) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      res_valid_q <= 1'b0;
      res_id_q    <= REQ_ID_0;
      res_s_q     <= '0;
      res_ovfl_q  <= 1'b0;
      last_q      <= REQ_ID_1;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_s_q     <= res_s_d;
      res_ovfl_q  <= res_ovfl_d;
      last_q      <= last_d;
    end
  end

  assign o_RES_VALID = res_valid_q;
  assign o_RES_ID    = res_id_q;
  assign o_RES_S     = res_s_q;
  assign o_RES_OVFL  = res_ovfl_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - randomized self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         rv [2];
  logic [N-1:0] ra [2];
  logic [N-1:0] rb [2];
  logic         rs [2];
  logic         res_ready;

  logic         o_REQ0_READY, o_REQ1_READY;
  logic         o_RES_VALID, o_RES_ID, o_RES_OVFL;
  logic [N-1:0] o_RES_S;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the result channel should show, and who won last.
  bit           m_valid;
  logic [N-1:0] m_s;
  bit           m_ovfl;
  bit           m_id;
  bit           m_last;

  always #5 clk = ~clk;

  addsub_arbiter #(.N(N)) dut (
    .i_CLK        (clk),
    .i_RSTn       (rstn),
    .i_REQ0_VALID (rv[0]),
    .o_REQ0_READY (o_REQ0_READY),
    .i_REQ0_A     (ra[0]),
    .i_REQ0_B     (rb[0]),
    .i_REQ0_SUB   (rs[0]),
    .i_REQ1_VALID (rv[1]),
    .o_REQ1_READY (o_REQ1_READY),
    .i_REQ1_A     (ra[1]),
    .i_REQ1_B     (rb[1]),
    .i_REQ1_SUB   (rs[1]),
    .o_RES_VALID  (o_RES_VALID),
    .i_RES_READY  (res_ready),
    .o_RES_ID     (o_RES_ID),
    .o_RES_S      (o_RES_S),
    .o_RES_OVFL   (o_RES_OVFL)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signed arithmetic in 64 bits; overflow means the true result leaves the 32-bit signed range.
  function automatic void model_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit sub,
                                   output logic [N-1:0] s, output bit ov);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    s  = r[N-1:0];
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic int exp_grant();
    if (!rstn) return -1;
    if (m_valid && !res_ready) return -1;
    if (rv[0] && rv[1]) return m_last ? 0 : 1;
    if (rv[0]) return 0;
    if (rv[1]) return 1;
    return -1;
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b, input bit sub);
    rv[k] = 1'b1;
    ra[k] = a;
    rb[k] = b;
    rs[k] = sub;
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_s     = '0;
    m_ovfl  = 0;
    m_id    = 0;
    m_last  = 1;
  endtask

  // One clock: check outputs mid-cycle, then advance the reference across the edge.
  task automatic cycle(input bit rnd);
    int g;
    g = exp_grant();
    #3;
    check("ready0",    {31'b0, o_REQ0_READY}, {31'b0, g == 0});
    check("ready1",    {31'b0, o_REQ1_READY}, {31'b0, g == 1});
    check("res_valid", {31'b0, o_RES_VALID},  {31'b0, m_valid});
    check("res_id",    {31'b0, o_RES_ID},     {31'b0, m_id});
    check("res_s",     o_RES_S,               m_s);
    check("res_ovfl",  {31'b0, o_RES_OVFL},   {31'b0, m_ovfl});
    @(posedge clk);
    #1;
    if (!rstn) begin
      model_reset();
    end else if (g >= 0) begin
      model_op(ra[g], rb[g], rs[g], m_s, m_ovfl);
      m_id    = g[0];
      m_last  = g[0];
      m_valid = 1;
      rv[g]   = 1'b0;
    end else if (res_ready) begin
      m_valid = 0;
    end
    if (rnd) begin
      for (int k = 0; k < 2; k++)
        if (!rv[k] && $urandom_range(3) != 0) set_op(k, pick(), pick(), $urandom_range(1) == 1);
      res_ready = $urandom_range(3) != 0;
    end
  endtask

  initial begin
    rstn      = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; ra[k] = '0; rb[k] = '0; rs[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    model_reset();

    // Reset held two cycles with both requesters asking.
    set_op(0, 32'd10, 32'd4, 1'b0);
    set_op(1, 32'd20, 32'd7, 1'b1);
    cycle(0);
    cycle(0);
    rstn = 1'b1;
    cycle(0);
    check("first_tie_id", {31'b0, o_RES_ID}, 32'd0);
    check("first_tie_s", o_RES_S, 32'd14);
    cycle(0);

    // Single operations, including the add that wraps to zero.
    set_op(0, 32'd5, 32'd3, 1'b1);
    cycle(0);
    check("sub_5_3", o_RES_S, 32'd2);
    set_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cycle(0);
    check("add_wrap_s", o_RES_S, 32'd0);
    check("add_wrap_id", {31'b0, o_RES_ID}, 32'd1);

    // Both held: grants must alternate starting from 0.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) if (!rv[k]) set_op(k, $urandom, $urandom, $urandom_range(1) == 1);
      cycle(0);
      check("rr_id", {31'b0, o_RES_ID}, i % 2);
    end

    // Backpressure for three cycles, then release.
    for (int k = 0; k < 2; k++) if (!rv[k]) set_op(k, $urandom, $urandom, 1'b0);
    res_ready = 1'b0;
    repeat (3) cycle(0);
    res_ready = 1'b1;
    cycle(0);
    cycle(0);

    // Subtract wrapping below zero.
    rv[0] = 1'b0; rv[1] = 1'b0;
    set_op(0, 32'd0, 32'd1, 1'b1);
    cycle(0);
    check("sub_wrap_s", o_RES_S, 32'hFFFF_FFFF);
    check("sub_wrap_ovfl", {31'b0, o_RES_OVFL}, 32'd0);
    set_op(1, 32'h8000_0000, 32'd1, 1'b1);
    cycle(0);
    check("sub_min_ovfl", {31'b0, o_RES_OVFL}, 32'd1);

    // Reset with a pending, stalled result; requester 0 must win the next tie.
    set_op(1, 32'd3, 32'd3, 1'b0);
    res_ready = 1'b0;
    cycle(0);
    set_op(0, 32'd9, 32'd1, 1'b0);
    rstn = 1'b0;
    cycle(0);
    check("midreset_valid", {31'b0, o_RES_VALID}, 32'd0);
    rstn      = 1'b1;
    res_ready = 1'b1;
    cycle(0);
    check("midreset_id", {31'b0, o_RES_ID}, 32'd0);
    check("midreset_s", o_RES_S, 32'd10);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) cycle(1);
    rv[0] = 1'b0; rv[1] = 1'b0; res_ready = 1'b1;
    repeat (3) cycle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
